// File: rtl/data_mem_pkg.sv
// Shared types and constants for the M-stage data-memory interface.
package data_mem_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } mem_state_t;

    localparam int         TIMEOUT_DEFAULT = 16;
    localparam logic [3:0] BE_WORD         = 4'b1111;

    function automatic logic [3:0] lane_be(input logic [1:0] lane);
        return 4'b0001 << lane;
    endfunction

endpackage

// File: rtl/byte_lane_align.sv
// Combinational byte-lane steering: store enables and replication, load lane extraction.
module byte_lane_align
    import data_mem_pkg::*;
(
    input  logic        st_byte,
    input  logic [1:0]  st_lane,
    input  logic [31:0] st_wdata,
    output logic [3:0]  st_be,
    output logic [31:0] st_wdata_rep,
    input  logic        ld_byte,
    input  logic [1:0]  ld_lane,
    input  logic [31:0] ld_rdata,
    output logic [31:0] ld_data
);

    // Store side: byte accesses replicate the low byte into every lane.
    always_comb begin
        if (st_byte) begin
            st_be        = lane_be(st_lane);
            st_wdata_rep = {4{st_wdata[7:0]}};
        end else begin
            st_be        = BE_WORD;
            st_wdata_rep = st_wdata;
        end
    end

    // Load side: byte loads zero-extend the addressed lane.
    always_comb begin
        ld_data = ld_rdata;
        if (ld_byte) begin
            case (ld_lane)
                2'd0:    ld_data = {24'h000000, ld_rdata[7:0]};
                2'd1:    ld_data = {24'h000000, ld_rdata[15:8]};
                2'd2:    ld_data = {24'h000000, ld_rdata[23:16]};
                2'd3:    ld_data = {24'h000000, ld_rdata[31:24]};
                default: ld_data = 32'h00000000;
            endcase
        end else begin
            ld_data = ld_rdata;
        end
    end

endmodule

// File: rtl/data_mem_interface.sv
// M-stage data-memory bus master: stalls the pipeline while a load/store runs on
// a ready/request bus, with misalignment and timeout faults.
module data_mem_interface
    import data_mem_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemReadM,
    input  logic        MemWriteM,
    input  logic        ByteM,
    input  logic [31:0] ALUResultM,
    input  logic [31:0] WriteDataM,
    output logic [31:0] ReadDataM,
    output logic        StallMem,
    output logic        MemFault,
    output logic        busReq,
    output logic        busWe,
    output logic [31:0] busAddr,
    output logic [31:0] busWData,
    output logic [3:0]  busBe,
    input  logic        busReady,
    input  logic [31:0] busRData
);

    localparam int               CNT_W   = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT - 1);

    logic             req_s;
    logic             misaligned_s;
    logic [3:0]       be_s;
    logic [31:0]      wdata_s;
    logic [31:0]      load_s;
    mem_state_t       state_r;
    logic [CNT_W-1:0] wait_cnt_r;
    logic             ld_byte_r;
    logic [1:0]       ld_lane_r;

    assign req_s        = MemReadM | MemWriteM;
    assign misaligned_s = !ByteM && (ALUResultM[1:0] != 2'b00);

    // The load lane is remembered at issue because busAddr carries only the word address.
    byte_lane_align u_align (
        .st_byte      (ByteM),
        .st_lane      (ALUResultM[1:0]),
        .st_wdata     (WriteDataM),
        .st_be        (be_s),
        .st_wdata_rep (wdata_s),
        .ld_byte      (ld_byte_r),
        .ld_lane      (ld_lane_r),
        .ld_rdata     (busRData),
        .ld_data      (load_s)
    );

    // Pipeline hold: only a live request in IDLE or an in-flight access stalls.
    always_comb begin
        StallMem = 1'b0;
        case (state_r)
            IDLE:    StallMem = req_s;
            ACCESS:  StallMem = 1'b1;
            DONE:    StallMem = 1'b0;
            default: StallMem = 1'b0;
        endcase
    end

    // Access sequencer with registered bus outputs, load capture and fault pulse.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r    <= IDLE;
            busReq     <= 1'b0;
            busWe      <= 1'b0;
            busAddr    <= 32'h00000000;
            busWData   <= 32'h00000000;
            busBe      <= 4'b0000;
            ReadDataM  <= 32'h00000000;
            MemFault   <= 1'b0;
            wait_cnt_r <= {CNT_W{1'b0}};
            ld_byte_r  <= 1'b0;
            ld_lane_r  <= 2'b00;
        end else begin
            MemFault <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (req_s && misaligned_s) begin
                        state_r   <= DONE;
                        MemFault  <= 1'b1;
                        ReadDataM <= 32'h00000000;
                    end else if (req_s) begin
                        state_r    <= ACCESS;
                        busReq     <= 1'b1;
                        busWe      <= MemWriteM;
                        busAddr    <= {ALUResultM[31:2], 2'b00};
                        busWData   <= wdata_s;
                        busBe      <= be_s;
                        wait_cnt_r <= {CNT_W{1'b0}};
                        ld_byte_r  <= ByteM;
                        ld_lane_r  <= ALUResultM[1:0];
                    end else begin
                        state_r <= IDLE;
                    end
                end
                ACCESS: begin
                    // Ready is tested first so a completion on the last allowed cycle wins.
                    if (busReady) begin
                        state_r <= DONE;
                        busReq  <= 1'b0;
                        if (!busWe) begin
                            ReadDataM <= load_s;
                        end
                    end else if (wait_cnt_r == CNT_MAX) begin
                        state_r   <= DONE;
                        busReq    <= 1'b0;
                        MemFault  <= 1'b1;
                        ReadDataM <= 32'h00000000;
                    end else begin
                        wait_cnt_r <= wait_cnt_r + 1'b1;
                    end
                end
                DONE: begin
                    state_r <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                    busReq  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_interface.sv
// Bench for data_mem_interface: transaction-level model of stall/bus/fault timing,
// directed corner cases plus randomized load/store traffic.
module tb_data_mem_interface;

    localparam int TB_TIMEOUT = 16;

    logic        clk;
    logic        reset;
    logic        MemReadM, MemWriteM, ByteM;
    logic [31:0] ALUResultM, WriteDataM, ReadDataM;
    logic        StallMem, MemFault;
    logic        busReq, busWe, busReady;
    logic [31:0] busAddr, busWData, busRData;
    logic [3:0]  busBe;

    data_mem_interface #(.TIMEOUT(TB_TIMEOUT)) dut (
        .clk        (clk),
        .reset      (reset),
        .MemReadM   (MemReadM),
        .MemWriteM  (MemWriteM),
        .ByteM      (ByteM),
        .ALUResultM (ALUResultM),
        .WriteDataM (WriteDataM),
        .ReadDataM  (ReadDataM),
        .StallMem   (StallMem),
        .MemFault   (MemFault),
        .busReq     (busReq),
        .busWe      (busWe),
        .busAddr    (busAddr),
        .busWData   (busWData),
        .busBe      (busBe),
        .busReady   (busReady),
        .busRData   (busRData)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Expected per-cycle outputs, written by the stimulus process.
    logic        exp_valid = 1'b0;
    logic        exp_stall, exp_req, exp_fault, exp_we;
    logic [3:0]  exp_be;
    logic [31:0] exp_addr, exp_wdata, exp_rd;
    logic [31:0] model_rd;

    // Observation totals and last bus snapshot, written only by the compare process.
    int          stall_tot = 0, fault_tot = 0, req_tot = 0;
    logic        snap_we;
    logic [3:0]  snap_be;
    logic [31:0] snap_addr, snap_wdata;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] load_val(input logic byt, input logic [1:0] lane,
                                             input logic [31:0] d);
        if (byt) return (d >> (8 * lane)) & 32'h000000FF;
        return d;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Compare process: DUT against the model once per cycle, away from the edge.
    always @(negedge clk) begin
        if (exp_valid) begin
            chk("StallMem", {31'd0, StallMem}, {31'd0, exp_stall});
            chk("busReq", {31'd0, busReq}, {31'd0, exp_req});
            chk("MemFault", {31'd0, MemFault}, {31'd0, exp_fault});
            chk("ReadDataM", ReadDataM, exp_rd);
            if (exp_req) begin
                chk("busWe", {31'd0, busWe}, {31'd0, exp_we});
                chk("busAddr", busAddr, exp_addr);
                chk("busWData", busWData, exp_wdata);
                chk("busBe", {28'd0, busBe}, {28'd0, exp_be});
            end
            if (StallMem === 1'b1) stall_tot++;
            if (MemFault === 1'b1) fault_tot++;
            if (busReq === 1'b1) begin
                req_tot++;
                snap_we    = busWe;
                snap_be    = busBe;
                snap_addr  = busAddr;
                snap_wdata = busWData;
            end
        end
    end

    // One M-stage instruction; the bus responds after wait_n wait cycles (>= TIMEOUT means never).
    task automatic run_instr(input logic rd, input logic wr, input logic byt,
                             input logic [31:0] addr, input logic [31:0] wd,
                             input int wait_n, input logic [31:0] rdata);
        logic mem, mis, to;
        int   n_acc;
        mem = rd | wr;
        mis = mem && !byt && (addr[1:0] != 2'b00);
        to  = 1'b0;
        MemReadM = rd; MemWriteM = wr; ByteM = byt; ALUResultM = addr; WriteDataM = wd;
        busReady  = 1'($urandom_range(0, 1));
        busRData  = $urandom;
        exp_stall = mem; exp_req = 1'b0; exp_fault = 1'b0; exp_rd = model_rd;
        exp_we    = wr;
        exp_addr  = {addr[31:2], 2'b00};
        exp_be    = byt ? (4'b0001 << addr[1:0]) : 4'b1111;
        exp_wdata = byt ? {4{wd[7:0]}} : wd;
        step();
        if (!mem) return;
        if (!mis) begin
            to    = (wait_n >= TB_TIMEOUT);
            n_acc = to ? TB_TIMEOUT : wait_n + 1;
            for (int k = 1; k <= n_acc; k++) begin
                busReady  = (!to && k == n_acc);
                busRData  = busReady ? rdata : $urandom;
                exp_stall = 1'b1;
                exp_req   = 1'b1;
                step();
            end
        end
        exp_stall = 1'b0;
        exp_req   = 1'b0;
        if (mis || to) begin
            exp_fault = 1'b1;
            model_rd  = 32'h00000000;
        end else if (!wr) begin
            model_rd = load_val(byt, addr[1:0], rdata);
        end
        exp_rd   = model_rd;
        busReady = 1'($urandom_range(0, 1));
        busRData = $urandom;
        step();
        exp_fault = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int s0, f0, r0;
        reset = 1'b0;
        MemReadM = 1'b0; MemWriteM = 1'b0; ByteM = 1'b0;
        ALUResultM = 32'h0; WriteDataM = 32'h0; busReady = 1'b0; busRData = 32'h0;
        model_rd = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busReq", {31'd0, busReq}, 32'd0);
        chk("rst_busWe", {31'd0, busWe}, 32'd0);
        chk("rst_busAddr", busAddr, 32'd0);
        chk("rst_busWData", busWData, 32'd0);
        chk("rst_busBe", {28'd0, busBe}, 32'd0);
        chk("rst_ReadDataM", ReadDataM, 32'd0);
        chk("rst_MemFault", {31'd0, MemFault}, 32'd0);
        chk("rst_StallMem", {31'd0, StallMem}, 32'd0);
        reset = 1'b1;
        exp_valid = 1'b1;

        // Word load, ready on first ACCESS cycle.
        s0 = stall_tot; f0 = fault_tot;
        run_instr(1'b1, 1'b0, 1'b0, 32'h00000100, 32'h0, 0, 32'hDEADBEEF);
        chk("ldw_stall_cycles", s0 == 0 ? stall_tot : stall_tot - s0, 32'd2);
        chk("ldw_fault", fault_tot - f0, 32'd0);
        chk("ldw_data", ReadDataM, 32'hDEADBEEF);

        // Byte store to lane 3.
        run_instr(1'b0, 1'b1, 1'b1, 32'h00000203, 32'h000000A5, 1, 32'h0);
        chk("strb_addr", snap_addr, 32'h00000200);
        chk("strb_be", {28'd0, snap_be}, 32'h00000008);
        chk("strb_wdata", snap_wdata, 32'hA5A5A5A5);
        chk("strb_we", {31'd0, snap_we}, 32'd1);
        chk("strb_keeps_rd", ReadDataM, 32'hDEADBEEF);

        // Byte load with three wait cycles.
        s0 = stall_tot;
        run_instr(1'b1, 1'b0, 1'b1, 32'h00000302, 32'h0, 3, 32'h11223344);
        chk("ldrb_data", ReadDataM, 32'h00000022);
        chk("ldrb_stall_cycles", stall_tot - s0, 32'd5);

        // Misaligned word load.
        s0 = stall_tot; f0 = fault_tot; r0 = req_tot;
        run_instr(1'b1, 1'b0, 1'b0, 32'h00000101, 32'h0, 0, 32'h12345678);
        chk("mis_fault", fault_tot - f0, 32'd1);
        chk("mis_stall_cycles", stall_tot - s0, 32'd1);
        chk("mis_req_cycles", req_tot - r0, 32'd0);
        chk("mis_data", ReadDataM, 32'd0);

        // Non-memory instruction, then a never-answered load.
        run_instr(1'b0, 1'b0, 1'b0, 32'h00000777, 32'h0, 0, 32'h0);
        run_instr(1'b1, 1'b0, 1'b0, 32'h00000104, 32'h0, 0, 32'h55AA55AA);
        s0 = stall_tot; f0 = fault_tot; r0 = req_tot;
        run_instr(1'b1, 1'b0, 1'b0, 32'h00000500, 32'h0, TB_TIMEOUT, 32'h0);
        chk("to_req_cycles", req_tot - r0, 32'd16);
        chk("to_fault", fault_tot - f0, 32'd1);
        chk("to_stall_cycles", stall_tot - s0, 32'd17);
        chk("to_data", ReadDataM, 32'd0);
        run_instr(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 0, 32'h0);

        // Ready on the final permitted cycle completes normally.
        f0 = fault_tot; r0 = req_tot;
        run_instr(1'b1, 1'b0, 1'b0, 32'h00000600, 32'h0, TB_TIMEOUT - 1, 32'h0BADF00D);
        chk("rw_fault", fault_tot - f0, 32'd0);
        chk("rw_req_cycles", req_tot - r0, 32'd16);
        chk("rw_data", ReadDataM, 32'h0BADF00D);

        // Read and write together behave as a write.
        run_instr(1'b1, 1'b1, 1'b0, 32'h00000700, 32'hCAFE1234, 2, 32'hFFFFFFFF);
        chk("rdwr_we", {31'd0, snap_we}, 32'd1);
        chk("rdwr_keeps_rd", ReadDataM, 32'h0BADF00D);

        // Reset asserted during the second ACCESS cycle.
        exp_valid = 1'b0;
        MemReadM = 1'b1; MemWriteM = 1'b0; ByteM = 1'b0; ALUResultM = 32'h00000400;
        busReady = 1'b0;
        step();
        step();
        #2 reset = 1'b0;
        #1;
        chk("midrst_busReq", {31'd0, busReq}, 32'd0);
        chk("midrst_fault", {31'd0, MemFault}, 32'd0);
        chk("midrst_stall_req", {31'd0, StallMem}, 32'd1);
        MemReadM = 1'b0;
        #1;
        chk("midrst_stall_idle", {31'd0, StallMem}, 32'd0);
        chk("midrst_rd", ReadDataM, 32'd0);
        step();
        reset = 1'b1;
        model_rd = 32'h0;
        exp_valid = 1'b1;
        f0 = fault_tot;
        run_instr(1'b1, 1'b0, 1'b0, 32'h00000400, 32'h0, 1, 32'hCAFEF00D);
        chk("postrst_data", ReadDataM, 32'hCAFEF00D);
        chk("postrst_fault", fault_tot - f0, 32'd0);

        // Randomized traffic.
        for (int i = 0; i < 200; i++) begin
            int unsigned kind;
            logic        rd_v, wr_v, byt_v;
            logic [31:0] a_v;
            int          w_v;
            kind  = $urandom_range(0, 9);
            byt_v = 1'($urandom_range(0, 1));
            if (kind < 2) begin
                rd_v = 1'b0;
                wr_v = 1'b0;
            end else begin
                rd_v = 1'($urandom_range(0, 1));
                wr_v = !rd_v || ($urandom_range(0, 3) == 0);
            end
            a_v = $urandom;
            if (!byt_v && $urandom_range(0, 3) != 0) a_v[1:0] = 2'b00;
            if ($urandom_range(0, 15) == 0) w_v = $urandom_range(TB_TIMEOUT - 1, TB_TIMEOUT + 1);
            else w_v = $urandom_range(0, 4);
            run_instr(rd_v, wr_v, byt_v, a_v, $urandom, w_v, $urandom);
        end

        exp_valid = 1'b0;
        @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/data_mem_interface.md
DATA_MEM_INTERFACE -- requirements
Module: data_mem_interface

Interface
REQ-001 The module SHALL have parameter TIMEOUT, default 16, meaning the maximum number of ACCESS cycles before a request is aborted.
REQ-002 The module SHALL have a single clock and an asynchronous, active-low reset, named clk and reset as in the rest of the codebase.
REQ-003 clk  in  1  rising-edge clock.
REQ-004 reset  in  1  asynchronous, active-low (0 = reset asserted).
REQ-005 MemReadM  in  1  M-stage load request.
REQ-006 MemWriteM  in  1  M-stage store request.
REQ-007 ByteM  in  1  byte access (LDRB/STRB); 0 = word access.
REQ-008 ALUResultM  in  32  byte address.
REQ-009 WriteDataM  in  32  store data.
REQ-010 ReadDataM  out  32  load result to the W pipeline register.
REQ-011 StallMem  out  1  holds the F/D/E/M pipeline registers.
REQ-012 MemFault  out  1  one-cycle pulse on a misaligned or timed-out access.
REQ-013 busReq  out  1  bus request, level, held until ready.
REQ-014 busWe  out  1  1 = write.
REQ-015 busAddr  out  32  word address ({ALUResultM[31:2],2'b00}).
REQ-016 busWData  out  32  lane-replicated write data.
REQ-017 busBe  out  4  byte enables.
REQ-018 busReady  in  1  bus completion strobe.
REQ-019 busRData  in  32  bus read data, valid when busReady=1.

Function
REQ-020 The FSM SHALL have three states: IDLE, ACCESS and DONE.
REQ-021 IDLE SHALL go to ACCESS when (MemReadM|MemWriteM) is set and the access is aligned; it SHALL go to DONE and pulse MemFault when ByteM=0 and ALUResultM[1:0]!=0; otherwise it SHALL stay in IDLE.
REQ-022 StallMem SHALL be combinational: 1 in IDLE while a request is present, 1 throughout ACCESS, and 0 in DONE.
REQ-023 busReq, busWe, busAddr, busWData and busBe SHALL be registered on IDLE->ACCESS and held stable until the cycle after busReady.
REQ-024 In ACCESS with busReady=1, the FSM SHALL go to DONE, capture load data into a register and deassert busReq on the next edge.
REQ-025 DONE SHALL go to IDLE unconditionally after one cycle; the pipeline advances at the end of DONE.
REQ-026 The minimum occupancy of the M stage by a memory operation SHALL be 3 cycles (IDLE, ACCESS with busReady=1, DONE); each extra wait cycle SHALL add one cycle.
REQ-027 A non-memory instruction in IDLE SHALL produce StallMem=0 with no latency.
REQ-028 Byte store SHALL drive busBe=4'b0001<<addr[1:0] and busWData={4{WriteDataM[7:0]}}.
REQ-029 Word access SHALL drive busBe=4'b1111 and busWData=WriteDataM.
REQ-030 Byte load SHALL drive ReadDataM with the zero-extended lane addr[1:0] of busRData; word load SHALL drive ReadDataM=busRData.
REQ-031 ReadDataM SHALL be driven from the capture register and held until the next capture.
REQ-032 The wait counter SHALL clear on ACCESS entry and increment each ACCESS cycle without busReady.
REQ-033 If the wait counter reaches TIMEOUT-1 without busReady, the FSM SHALL go to DONE, drop busReq, pulse MemFault and load ReadDataM=0; a write in that case is lost.
REQ-034 A misaligned access SHALL load ReadDataM=0 and generate no bus transaction.
REQ-035 If MemReadM and MemWriteM are both 1, the access SHALL be treated as a write.
REQ-036 busReady outside ACCESS SHALL be ignored.
REQ-037 busReady arriving in the same cycle as the timeout SHALL count as a successful completion (ready wins).

Reset
REQ-038 Asserting reset (0) SHALL asynchronously force state=IDLE, busReq=0, busWe=0, busAddr=0, busWData=0, busBe=0, ReadDataM=0, MemFault=0 and wait counter=0.
REQ-039 Reset asserted mid-ACCESS SHALL drop busReq immediately and SHALL NOT pulse MemFault.
REQ-040 After reset release, StallMem SHALL depend only on the inputs in IDLE.

Structure
REQ-041 The state enum, the TIMEOUT default and the BE_WORD (4'b1111) constant SHALL reside in the shared package data_mem_pkg.
REQ-042 Lane replication, enable generation and load extraction SHALL be in one combinational sub-module, byte_lane_align.

Verification
REQ-043 Word load at 0x100, busReady on the first ACCESS cycle, busRData=0xDEADBEEF -> StallMem=1 for 2 cycles, ReadDataM=0xDEADBEEF in DONE, no MemFault.
REQ-044 STRB at 0x203 with WriteDataM=0x000000A5 -> busAddr=0x200, busBe=4'b1000, busWData=0xA5A5A5A5, busWe=1.
REQ-045 LDRB at 0x302, busRData=0x11223344, 3 wait cycles -> ReadDataM=0x00000022, StallMem high for 5 cycles.
REQ-046 Word load at 0x101 -> no busReq, MemFault pulses 1 cycle, ReadDataM=0, stall lasts 1 cycle.
REQ-047 busReady never asserted with TIMEOUT=16 -> busReq drops after 16 ACCESS cycles, MemFault pulses once, FSM returns to IDLE.
REQ-048 reset driven low during the 2nd ACCESS cycle -> busReq=0 within the same cycle, state=IDLE, no MemFault; a load after release completes normally.
